// File: rtl/dmem_pkg.sv
// Shared encodings and types for the wait-stated scratch data memory.
package dmem_pkg;

   localparam int CNT_W = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_CLEAR  = 3'd0,
      S_IDLE   = 3'd1,
      S_WAIT   = 3'd2,
      S_ACCESS = 3'd3,
      S_RESP   = 3'd4
   } state_e;

   // Request fields captured on acceptance; live inputs are ignored afterwards.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign_ext;
      logic [31:0] adr;
      logic [31:0] wdata;
   } acc_t;

endpackage

// File: rtl/dmem_waitstate_if.sv
// Request/response bus between the MEM stage and the scratch data memory.
interface dmem_waitstate_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] adr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (
      output req, we, size, sign_ext, adr, wdata,
      input  rdata, ready, err, busy
   );

   modport slave (
      input  req, we, size, sign_ext, adr, wdata,
      output rdata, ready, err, busy
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering: store enables/data placement and load extract/extend.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] ldata
);

   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   // Lane 3 holds byte offset 0, so enables shift down as the offset grows.
   always_comb begin
      be    = 4'b0000;
      wword = 32'h0;
      case (size)
         SZ_BYTE: begin
            be    = 4'b1000 >> off;
            wword = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be    = off[1] ? 4'b0011 : 4'b1100;
            wword = {2{wdata[15:0]}};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            wword = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (off)
         2'd0:    ld_b = rword[31:24];
         2'd1:    ld_b = rword[23:16];
         2'd2:    ld_b = rword[15:8];
         default: ld_b = rword[7:0];
      endcase
      ld_h = off[1] ? rword[15:0] : rword[31:16];
      case (size)
         SZ_BYTE: ldata = {{24{sign_ext & ld_b[7]}}, ld_b};
         SZ_HALF: ldata = {{16{sign_ext & ld_h[15]}}, ld_h};
         default: ldata = rword;
      endcase
   end

endmodule

// File: rtl/dmem_waitstate.sv
// Wait-stated, self-clearing big-endian scratch RAM with req/ready handshake.
module dmem_waitstate
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES = 256,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_waitstate_if.slave bus
);

   localparam int WORDS = DEPTH_BYTES / 4;
   localparam int AW    = $clog2(WORDS);

   localparam logic [2:0] ST_CLEAR  = S_CLEAR;
   localparam logic [2:0] ST_IDLE   = S_IDLE;
   localparam logic [2:0] ST_WAIT   = S_WAIT;
   localparam logic [2:0] ST_ACCESS = S_ACCESS;
   localparam logic [2:0] ST_RESP   = S_RESP;

   logic [2:0]       state;
   logic [AW-1:0]    clr_idx;
   logic [CNT_W-1:0] cnt;
   acc_t             lat;
   logic [31:0]      mem [WORDS];

   logic [31:0]      off;
   logic [AW-1:0]    idx;
   logic             fault;
   logic [3:0]       be;
   logic [31:0]      wword;
   logic [31:0]      ldata;
   logic [31:0]      rword;

   assign off   = lat.adr - 32'(BASE_ADDR);
   assign idx   = off[AW+1:2];
   assign rword = mem[idx];

   // Offset is unsigned, so addresses below the base wrap high and fail the range test.
   always_comb begin
      fault = (off >= 32'(DEPTH_BYTES));
      case (lat.size)
         SZ_HALF: fault = fault | off[0];
         SZ_WORD: fault = fault | (off[1:0] != 2'b00);
         SZ_BYTE: ;
         default: fault = 1'b1;
      endcase
   end

   dmem_lane_align u_align (
      .size     (lat.size),
      .off      (off[1:0]),
      .sign_ext (lat.sign_ext),
      .wdata    (lat.wdata),
      .rword    (rword),
      .be       (be),
      .wword    (wword),
      .ldata    (ldata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_CLEAR;
         clr_idx   <= '0;
         cnt       <= '0;
         lat       <= '0;
         bus.ready <= 1'b0;
         bus.err   <= 1'b0;
         bus.rdata <= 32'h0;
         bus.busy  <= 1'b1;
      end else begin
         bus.ready <= 1'b0;
         bus.err   <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == AW'(WORDS - 1)) begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (bus.req) begin
                  lat.we       <= bus.we;
                  lat.size     <= bus.size;
                  lat.sign_ext <= bus.sign_ext;
                  lat.adr      <= bus.adr;
                  lat.wdata    <= bus.wdata;
                  cnt          <= CNT_W'(WAIT_STATES);
                  state        <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               bus.ready <= 1'b1;
               bus.err   <= fault;
               if (fault)        bus.rdata <= 32'h0;
               else if (!lat.we) bus.rdata <= ldata;
               state <= ST_RESP;
            end
            ST_RESP:  state <= ST_IDLE;
            default:  state <= ST_CLEAR;
         endcase
      end
   end

   // Storage is not reset; the CLEAR walk zeroes it instead.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_idx] <= 32'h0;
      end else if (state == ST_ACCESS && lat.we && !fault) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_waitstate.sv
// Scoreboard bench: driver pushes model-predicted responses, monitor pops on ready.
module tb_dmem_waitstate;
   import dmem_pkg::*;

   localparam int DEPTH = 256;
   localparam int BASE  = 1024;
   localparam int WS    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst0 = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_waitstate_if bus ();
   dmem_waitstate_if bus0 ();

   dmem_waitstate #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
      .clk (clk), .rst (rst), .bus (bus.slave)
   );

   dmem_waitstate #(.DEPTH_BYTES(16), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
      .clk (clk), .rst (rst0), .bus (bus0.slave)
   );

   typedef struct {
      bit          err;
      bit          chk_rd;
      logic [31:0] rd;
      int          due;
   } exp_t;

   exp_t       q[$];
   logic [7:0] mem_m [DEPTH];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
   endtask

   // Reference: address arithmetic and byte-array accesses straight from the rules.
   task automatic predict(input bit w, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] d, output exp_t e);
      logic [31:0] off;
      logic [31:0] v;
      int          nb;
      bit          f;
      off = a - 32'(BASE);
      nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      f   = (off >= 32'(DEPTH)) || (sz == 2'b11) || ((off % nb) != 0);
      e.err = f;
      e.chk_rd = f || !w;
      e.rd = 32'h0;
      e.due = 0;
      if (!f && w) begin
         for (int i = 0; i < nb; i++)
            mem_m[int'(off) + i] = 8'(d >> (8 * (nb - 1 - i)));
      end else if (!f) begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mem_m[int'(off) + i]);
         if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         e.rd = v;
      end
   endtask

   task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   g;
      @(negedge clk);
      bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.adr = a; bus.wdata = d;
      bus.req = 1'b1;
      g = 0;
      while (bus.busy && g < 500) begin @(negedge clk); g++; end
      if (bus.busy) begin
         check("busy_timeout", 32'(bus.busy), 32'h0);
         bus.req = 1'b0;
         return;
      end
      predict(w, sz, sx, a, d, e);
      e.due = cyc + 1 + WS + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      bus.we = ~w; bus.size = 2'($urandom); bus.sign_ext = ~sx;
      bus.adr = $urandom; bus.wdata = $urandom;
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.ready && g < 50);
      if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'h1);
      @(posedge clk);
      #1 bus.req = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.ready) begin
         if (q.size() == 0) begin
            check("unexpected_ready", 32'(bus.ready), 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("err", 32'(bus.err), 32'(e.err));
            if (e.chk_rd) check("rdata", bus.rdata, e.rd);
            check("ready_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic acc0(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat, output int nr);
      int g;
      int accc;
      lat = -1; nr = 0; rd = 32'h0; e = 1'b0;
      @(negedge clk);
      bus0.we = w; bus0.size = sz; bus0.sign_ext = 1'b0; bus0.adr = a; bus0.wdata = d;
      bus0.req = 1'b1;
      g = 0;
      while (bus0.busy && g < 100) begin @(negedge clk); g++; end
      accc = cyc + 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus0.ready) begin
            nr++;
            if (lat < 0) begin lat = cyc - accc; rd = bus0.rdata; e = bus0.err; end
            @(posedge clk);
            #1 bus0.req = 1'b0;
         end
      end
      bus0.req = 1'b0;
   endtask

   initial begin
      int n;
      int g;
      logic [31:0] rd0;
      logic        e0;
      int          lat0, nr0;
      bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
      bus.adr = 32'h0; bus.wdata = 32'h0;
      bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = SZ_WORD; bus0.sign_ext = 1'b0;
      bus0.adr = 32'h0; bus0.wdata = 32'h0;
      model_clear();

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.ready), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h1);
      rst = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (bus.busy && n < 200);
      check("clear_cycles", 32'(n), 32'd64);

      issue(0, SZ_WORD, 0, 32'd1024, 32'h0);
      issue(1, SZ_WORD, 0, 32'd1028, 32'h1122_3344);
      issue(0, SZ_WORD, 0, 32'd1028, 32'h0);
      issue(1, SZ_WORD, 0, 32'd1032, 32'h80FF_7F01);
      issue(0, SZ_BYTE, 1, 32'd1032, 32'h0);
      issue(0, SZ_BYTE, 0, 32'd1034, 32'h0);
      issue(0, SZ_HALF, 1, 32'd1034, 32'h0);
      issue(1, SZ_BYTE, 0, 32'd1033, 32'hFFFF_FFAB);
      issue(0, SZ_WORD, 0, 32'd1032, 32'h0);
      issue(1, SZ_HALF, 0, 32'd1034, 32'h1234_CDEF);
      issue(0, SZ_WORD, 0, 32'd1032, 32'h0);
      issue(0, SZ_WORD, 0, 32'd1030, 32'h0);
      issue(1, SZ_WORD, 0, 32'd1280, 32'hDEAD_BEEF);
      issue(0, SZ_WORD, 0, 32'd1024, 32'h0);
      issue(0, 2'b11,   0, 32'd1036, 32'h0);
      issue(1, 2'b11,   0, 32'd1036, 32'hFFFF_FFFF);
      issue(0, SZ_WORD, 0, 32'd1036, 32'h0);

      for (int i = 0; i < 80; i++)
         issue(1'($urandom), 2'($urandom), 1'($urandom),
               32'd1016 + $urandom_range(0, 280), $urandom);
      for (int i = 0; i < 16; i++)
         issue(0, SZ_WORD, 0, 32'(BASE + 4 * $urandom_range(0, 63)), 32'h0);

      // Abandon a store mid-wait with reset; the clear must run again from scratch.
      @(negedge clk);
      bus.we = 1'b1; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
      bus.adr = 32'd1040; bus.wdata = 32'hDEAD_BEEF; bus.req = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      bus.req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst2_busy", 32'(bus.busy), 32'h1);
      rst = 1'b0;
      model_clear();
      issue(0, SZ_WORD, 0, 32'd1040, 32'h0);
      issue(0, SZ_WORD, 0, 32'd1028, 32'h0);

      g = 0;
      while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
      check("scoreboard_drain", 32'(q.size()), 32'h0);

      rst0 = 1'b0;
      acc0(1, SZ_WORD, 32'd1028, 32'hCAFE_F00D, rd0, e0, lat0, nr0);
      check("ws0_store_latency", 32'(lat0), 32'd1);
      check("ws0_store_once", 32'(nr0), 32'd1);
      check("ws0_store_err", 32'(e0), 32'h0);
      acc0(0, SZ_WORD, 32'd1028, 32'h0, rd0, e0, lat0, nr0);
      check("ws0_load_rdata", rd0, 32'hCAFE_F00D);
      check("ws0_load_once", 32'(nr0), 32'd1);
      acc0(0, SZ_WORD, 32'd1040, 32'h0, rd0, e0, lat0, nr0);
      check("ws0_range_err", 32'(e0), 32'h1);
      check("ws0_range_rdata", rd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
